// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multicycle ALU.
// Imported by alu_multicycle and mul_div_iter.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_WB
  } state_e;

  // Ops that go through the iterative core rather than EXEC.
  function automatic logic is_iter_op(
    input logic [2:0] op,
    input logic       b_nz
  );
    return (op == OP_MUL) || ((op == OP_DIV) && b_nz);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier and restoring divider.
// One step per clock; result/ovf show the value after the current step.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         last
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   sh_q;
  logic [N-1:0]   rem_q;
  logic [N-1:0]   dvs_q;
  logic [CW-1:0]  cnt_q;
  logic           div_q;

  logic [2*N-1:0] acc_d;
  logic [N:0]     rsh;
  logic [N:0]     rdiff;
  logic           fits;
  logic [N-1:0]   rem_d;
  logic [N-1:0]   quo_d;

  // Combinational view of one multiply or divide step.
  always_comb begin
    acc_d = acc_q + (sh_q[0] ? mcand_q : '0);
    rsh   = {rem_q, sh_q[N-1]};
    rdiff = rsh - {1'b0, dvs_q};
    fits  = ~rdiff[N];
    rem_d = fits ? rdiff[N-1:0] : rsh[N-1:0];
    quo_d = {sh_q[N-2:0], fits};
  end

  assign result = div_q ? quo_d : acc_d[N-1:0];
  assign ovf    = ~div_q & (|acc_d[2*N-1:N]);
  assign last   = (cnt_q == CW'(1));

  // Operand load on accept, then one step per edge until count hits 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else if (load) begin
      acc_q   <= '0;
      mcand_q <= {{N{1'b0}}, a};
      sh_q    <= is_div ? a : b;
      rem_q   <= '0;
      dvs_q   <= b;
      cnt_q   <= CW'(N);
      div_q   <= is_div;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (div_q) begin
        rem_q <= rem_d;
        sh_q  <= quo_d;
      end else begin
        acc_q   <= acc_d;
        mcand_q <= mcand_q << 1;
        sh_q    <= sh_q >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU execution stage driving the register bank write port.
// Single-cycle ops go via EXEC, MUL/DIV via the iterative core.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int N  = 8,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [RA-1:0] dest,
  output logic [N-1:0]  wd3,
  output logic [RA-1:0] wa3,
  output logic          we3,
  output logic          busy,
  output logic          done,
  output logic          zero,
  output logic          carry,
  output logic          dz
);

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [2:0]    op_q;
  logic [RA-1:0] dest_q;
  logic          busy_q;

  logic [N-1:0]  wd3_q;
  logic [RA-1:0] wa3_q;
  logic          we3_q;
  logic          done_q;
  logic          zero_q;
  logic          carry_q;
  logic          dz_q;

  logic          accept;
  logic          iter_go;
  logic          wb_fire;
  logic [N-1:0]  core_res;
  logic          core_ovf;
  logic          core_last;

  logic [N:0]    sum;
  logic [N:0]    dif;
  logic [N-1:0]  res_d;
  logic          carry_d;
  logic          dz_d;
  logic          zero_d;

  assign accept  = (state_q == S_IDLE) && start;
  assign iter_go = accept && is_iter_op(op, |b);
  assign wb_fire = (state_q == S_EXEC) ||
                   ((state_q == S_ITER) && core_last);

  mul_div_iter #(
    .N (N)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (iter_go),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .result (core_res),
    .ovf    (core_ovf),
    .last   (core_last)
  );

  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign dif = {1'b0, a_q} - {1'b0, b_q};

  // Result and flag selection for the latched opcode.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    dz_d    = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res_d   = sum[N-1:0];
        carry_d = sum[N];
      end
      OP_SUB: begin
        res_d   = dif[N-1:0];
        carry_d = dif[N];
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_SLTU: res_d = {{(N-1){1'b0}}, dif[N]};
      OP_MUL: begin
        res_d   = core_res;
        carry_d = core_ovf;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_d = '1;
          dz_d  = 1'b1;
        end else begin
          res_d = core_res;
        end
      end
    endcase
    zero_d = (res_d == '0);
  end

  // Control FSM: accept, execute or iterate, write back, release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      dest_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            dest_q  <= dest;
            busy_q  <= 1'b1;
            state_q <= iter_go ? S_ITER : S_EXEC;
          end
        end
        S_EXEC: state_q <= S_WB;
        S_ITER: begin
          if (core_last) state_q <= S_WB;
        end
        S_WB: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write port and flags: pulses for one cycle, data held until next WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd3_q   <= '0;
      wa3_q   <= '0;
      we3_q   <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      we3_q  <= wb_fire;
      done_q <= wb_fire;
      if (wb_fire) begin
        wd3_q   <= res_d;
        wa3_q   <= dest_q;
        zero_q  <= zero_d;
        carry_q <= carry_d;
        dz_q    <= dz_d;
      end
    end
  end

  assign wd3   = wd3_q;
  assign wa3   = wa3_q;
  assign we3   = we3_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle.
// Hand-computed vectors checked with immediate assertions.
module tb_alu_multicycle;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] dest;
  logic [7:0] wd3;
  logic [2:0] wa3;
  logic       we3;
  logic       busy;
  logic       done;
  logic       zero;
  logic       carry;
  logic       dz;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.N(8), .RA(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .dest  (dest),
    .wd3   (wd3),
    .wa3   (wa3),
    .we3   (we3),
    .busy  (busy),
    .done  (done),
    .zero  (zero),
    .carry (carry),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] d);
    op    = o;
    a     = x;
    b     = y;
    dest  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until we3 is seen, bounded; lat counts cycles from base.
  task automatic wait_wb(input int base, output int lat);
    lat = base;
    do begin
      tick();
      lat++;
    end while (!we3 && lat < 40);
  endtask

  task automatic op_test(input string tag, input logic [2:0] o,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic [2:0] d, input int exp_lat,
                         input logic [7:0] ewd, input logic ec,
                         input logic ez, input logic edz);
    int lat;
    issue(o, x, y, d);
    chk({tag, " busy"}, busy, 1);
    wait_wb(0, lat);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " we3"}, we3, 1);
    chk({tag, " done"}, done, 1);
    chk({tag, " wd3"}, wd3, ewd);
    chk({tag, " wa3"}, wa3, d);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " zero"}, zero, ez);
    chk({tag, " dz"}, dz, edz);
    tick();
    chk({tag, " we3 off"}, we3, 0);
    chk({tag, " busy off"}, busy, 0);
    chk({tag, " wd3 hold"}, wd3, ewd);
  endtask

  initial begin
    int lat;
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 8'h00;
    b     = 8'h00;
    dest  = 3'd0;
    tick();
    tick();
    chk("rst wd3", wd3, 0);
    chk("rst wa3", wa3, 0);
    chk("rst we3", we3, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst flags", {zero, carry, dz}, 0);
    rst = 1'b0;
    tick();

    op_test("add", 3'b000, 8'd200, 8'd100, 3'd3, 1, 8'h2C, 1, 0, 0);
    op_test("sub_lt", 3'b001, 8'd5, 8'd7, 3'd1, 1, 8'hFE, 1, 0, 0);
    op_test("sub_eq", 3'b001, 8'd9, 8'd9, 3'd2, 1, 8'h00, 0, 1, 0);
    op_test("or", 3'b011, 8'h0F, 8'hA0, 3'd4, 1, 8'hAF, 0, 0, 0);
    op_test("sltu", 3'b101, 8'd3, 8'd200, 3'd6, 1, 8'h01, 0, 0, 0);
    op_test("sltu_f", 3'b101, 8'd200, 8'd3, 3'd6, 1, 8'h00, 0, 1, 0);
    op_test("mul", 3'b110, 8'd13, 8'd11, 3'd5, 8, 8'h8F, 0, 0, 0);
    op_test("mul_ov", 3'b110, 8'd20, 8'd20, 3'd5, 8, 8'h90, 1, 0, 0);
    op_test("div", 3'b111, 8'd100, 8'd7, 3'd1, 8, 8'h0E, 0, 0, 0);
    op_test("div_big", 3'b111, 8'd255, 8'd1, 3'd1, 8, 8'hFF, 0, 0, 0);
    op_test("div_z", 3'b111, 8'd100, 8'd0, 3'd2, 1, 8'hFF, 0, 0, 1);

    // start while busy is ignored
    issue(3'b110, 8'd13, 8'd11, 3'd5);
    tick();
    op    = 3'b000;
    a     = 8'd1;
    b     = 8'd1;
    dest  = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wb(2, lat);
    chk("ign lat", lat, 8);
    chk("ign wd3", wd3, 8'h8F);
    chk("ign wa3", wa3, 3'd5);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (we3) pulses++;
    end
    chk("ign extra we3", pulses, 0);
    chk("ign busy", busy, 0);

    // reset mid-multiply aborts
    issue(3'b110, 8'd20, 8'd20, 3'd6);
    tick();
    tick();
    tick();
    chk("abort busy pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort wd3", wd3, 0);
    chk("abort wa3", wa3, 0);
    chk("abort busy", busy, 0);
    chk("abort pulses", {we3, done}, 0);
    chk("abort flags", {zero, carry, dz}, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (we3) pulses++;
    end
    chk("abort no we3", pulses, 0);
    chk("abort idle", busy, 0);

    // start held high: AND then XOR back to back
    op    = 3'b010;
    a     = 8'hF0;
    b     = 8'h3C;
    dest  = 3'd7;
    start = 1'b1;
    tick();
    wait_wb(0, lat);
    chk("hold and lat", lat, 1);
    chk("hold and wd3", wd3, 8'h30);
    chk("hold and done", done, 1);
    op = 3'b100;
    wait_wb(0, lat);
    chk("hold gap", lat, 3);
    chk("hold xor wd3", wd3, 8'hCC);
    chk("hold xor done", done, 1);
    chk("hold xor wa3", wa3, 3'd7);
    start = 1'b0;
    tick();
    tick();
    chk("hold end busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
